ring_entropy_pool: RTL
======================

# ring_entropy_pool

- Parametrised successor to the fixed ring-oscillator harvesting in `digitalcore_macro`.
- Drives a common `start` to `NUM_RINGS` ring/collapse-ring macros and samples their free-running `clk_out` lines.
- XOR-combines the masked samples, runs a repetition-count health test, packs bits into words and buffers them in a FIFO for the Wishbone/LA register front end.
- Lives inside the digital core, clocked by the Wishbone clock.

## Interface
Parameters:
- `NUM_RINGS`, 8, number of ring clock inputs (1–32)
- `WORD_W`, 32, packed output word width
- `FIFO_DEPTH`, 8, output words buffered (power of two, ≥2)
- `WARMUP_CYCLES`, 64, cycles between `start_o` rising and first sample
- `REP_LIMIT`, 32, identical consecutive bits that trip the health test

Ports (one clock; reset is synchronous and active-high):
- `wb_clk_i`  in  1  system clock
- `wb_rst_i`  in  1  synchronous active-high reset
- `ring_clk_i`  in  NUM_RINGS  asynchronous ring oscillator outputs
- `enable_i`  in  1  level; run harvesting
- `ring_mask_i`  in  NUM_RINGS  1 = ring contributes to the XOR
- `sample_div_i`  in  16  sample period = `sample_div_i`+1 cycles
- `clear_i`  in  1  pulse; clears sticky flags, leaves FAULT
- `start_o`  out  1  common ring start/enable
- `rd_data_o`  out  WORD_W  FIFO head word (show-ahead)
- `rd_valid_o`  out  1  FIFO non-empty
- `rd_ready_i`  in  1  pop when `rd_valid_o` is high
- `fifo_count_o`  out  $clog2(FIFO_DEPTH)+1  words held
- `overflow_o`  out  1  sticky; a word was dropped
- `health_fail_o`  out  1  sticky; repetition test tripped
- `busy_o`  out  1  state is WARMUP or RUN

## Operation
- Each `ring_clk_i` bit passes through a 2-flop synchroniser, `sync[i]`.
- Sample bit is `^(sync & ring_mask_i)`.
- Prescaler counts 0..`sample_div_i`. It runs only in RUN and emits `tick` on terminal count.
- FSM states:
  - IDLE: `start_o`=0. Goes to WARMUP when `enable_i`=1.
  - WARMUP: `start_o`=1. The warm-up counter counts to `WARMUP_CYCLES`-1, then the FSM goes to RUN with the prescaler at 0.
  - RUN: `start_o`=1. On each `tick`, the bit shifts into the accumulator LSB-first, i.e. the first sample lands in bit 0. After `WORD_W` ticks the word is pushed and the bit counter wraps to 0.
  - FAULT: `start_o`=0. Entered from RUN when the repetition counter reaches `REP_LIMIT`. It sets `health_fail_o`, and the partial word is discarded. FAULT is left only by `clear_i`, which goes to IDLE.
- `enable_i`=0 in WARMUP or RUN:
  - next state is IDLE;
  - partial accumulator, bit counter, prescaler and repetition counter are cleared;
  - FIFO contents are kept.
- Repetition counter:
  - resets to 1 on a tick whose bit differs from the previous bit;
  - increments on equal bits;
  - the first tick after entering RUN loads 1.
- FIFO push:
  - If the FIFO is full with no simultaneous pop, the word is dropped and `overflow_o` is set.
  - Full with a simultaneous pop: the push is accepted and the count is unchanged.
- Pop on empty is ignored.
- `clear_i` clears `overflow_o` and `health_fail_o`. When `clear_i` and a trip occur in the same cycle, the trip wins: the flag stays 1.
- `ring_mask_i` and `sample_div_i` may change at any time. They take effect on the next cycle.

## Timing
Reset values:
- FSM in IDLE;
- `start_o`, `rd_valid_o`, `overflow_o`, `health_fail_o`, `busy_o` = 0;
- `fifo_count_o` = 0;
- `rd_data_o` = 0;
- all counters = 0.

Cycle-level behaviour:
- A ring edge reaches `sync` 2–3 cycles later.
- `start_o` rises the cycle after `enable_i` is first seen high.
- The first `tick` occurs `WARMUP_CYCLES` + `sample_div_i`+1 cycles after `start_o` rises.
- The word is written on the edge after the `WORD_W`-th tick. `rd_valid_o` and the new `fifo_count_o` are visible on the following cycle.
- A pop takes effect on the edge where `rd_valid_o`&&`rd_ready_i`. The next head word appears the same edge.
- FAULT is entered on the edge after the tripping tick. `start_o` falls on that edge.
- Reset mid-operation: all state returns to reset values on the next edge, and the FIFO is emptied.

## Structure
- Shared package `ring_pkg` holds:
  - the FSM state enum (`RS_IDLE`, `RS_WARMUP`, `RS_RUN`, `RS_FAULT`);
  - the default `WORD_W`/`FIFO_DEPTH` constants, also used by the register map.
- One sub-module: `ring_sync_fifo`, a parametrised synchronous show-ahead FIFO with count, full and empty.
- The synchroniser is an inline generate loop, not a separate module.

## Test plan
- Reset → all outputs 0; `start_o` stays 0 for 100 cycles with `enable_i`=0.
- `WORD_W`=32, `sample_div_i`=3, ring 0 driven as an alternating-bit pattern synchronous to ticks, mask=0x01:
  - `start_o` rises 1 cycle after enable;
  - first word `0x55555555` or `0xAAAAAAAA`;
  - `rd_valid_o` asserts 64+4·32+2 cycles after `start_o` rises (±2 for synchroniser alignment).
- `ring_mask_i`=0 → constant 0 → `health_fail_o`=1 and `start_o`=0 after the 32nd tick; `clear_i` → IDLE, flag 0.
- Hold `rd_ready_i`=0 and run 9 words into the depth-8 FIFO:
  - `fifo_count_o`=8, `overflow_o`=1;
  - with `rd_ready_i` high on the 10th push cycle, the count stays 8 and the flag stays set.
- Drop `enable_i` mid-word after 10 ticks, then re-enable:
  - no partial word is pushed;
  - the next word contains only post-re-enable samples;
  - existing FIFO words are unchanged.
- Assert `wb_rst_i` while in RUN with 3 words queued → `fifo_count_o`=0, `start_o`=0 on the next cycle.

Source files
------------

// File: rtl/ring_pkg.sv
// ring_pkg
//   Shared definitions for the ring-oscillator entropy pool and the register
//   front end: FSM state encoding and the default word/FIFO geometry.
package ring_pkg;

  localparam int unsigned RING_WORD_W     = 32;
  localparam int unsigned RING_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    RS_IDLE   = 2'd0,
    RS_WARMUP = 2'd1,
    RS_RUN    = 2'd2,
    RS_FAULT  = 2'd3
  } ring_state_e;

endpackage

// File: rtl/ring_sync_fifo.sv
// ring_sync_fifo
//   Synchronous show-ahead FIFO with occupancy count.
//   clk, rst      : clock, synchronous active-high reset (empties the FIFO)
//   wr_en/wr_data : push request; accepted when not full, or when full and a
//                   pop happens on the same edge
//   rd_en         : pop request; ignored when empty
//   rd_data       : head word (zero while empty)
//   count         : words held; full/empty flags
module ring_sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  // When full, the slot being written is the head that is leaving this edge.
  assign do_wr = wr_en && (!full || do_rd);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ring_entropy_pool.sv
// ring_entropy_pool
//   Harvests entropy from NUM_RINGS free-running ring oscillators: the ring
//   outputs are synchronised, masked and XOR-folded into one sample bit per
//   prescaler tick, checked by a repetition-count health test, packed
//   LSB-first into WORD_W-bit words and queued in a show-ahead FIFO.
//   wb_clk_i/wb_rst_i : clock, synchronous active-high reset
//   ring_clk_i        : asynchronous ring outputs
//   enable_i          : run harvesting (level)
//   ring_mask_i       : per-ring XOR contribution enable
//   sample_div_i      : sample period minus one, in clocks
//   clear_i           : clears overflow_o / health_fail_o, exits FAULT
//   start_o           : common ring start
//   rd_data_o/rd_valid_o/rd_ready_i/fifo_count_o : FIFO read side
//   overflow_o        : sticky, a word was dropped on a full FIFO
//   health_fail_o     : sticky, repetition test tripped
//   busy_o            : warming up or running
module ring_entropy_pool
  import ring_pkg::*;
#(
  parameter int unsigned NUM_RINGS     = 8,
  parameter int unsigned WORD_W        = RING_WORD_W,
  parameter int unsigned FIFO_DEPTH    = RING_FIFO_DEPTH,
  parameter int unsigned WARMUP_CYCLES = 64,
  parameter int unsigned REP_LIMIT     = 32
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic [NUM_RINGS-1:0]          ring_clk_i,
  input  logic                          enable_i,
  input  logic [NUM_RINGS-1:0]          ring_mask_i,
  input  logic [15:0]                   sample_div_i,
  input  logic                          clear_i,
  output logic                          start_o,
  output logic [WORD_W-1:0]             rd_data_o,
  output logic                          rd_valid_o,
  input  logic                          rd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
  output logic                          overflow_o,
  output logic                          health_fail_o,
  output logic                          busy_o
);

  localparam int unsigned BW = $clog2(WORD_W);
  localparam int unsigned WW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
  localparam int unsigned RW = $clog2(REP_LIMIT + 1);

  ring_state_e       state;
  logic [NUM_RINGS-1:0] sync_q;
  logic              sample_bit;
  logic [15:0]       presc;
  logic [WW-1:0]     warm_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [RW-1:0]     rep_cnt;
  logic [RW-1:0]     rep_next;
  logic              prev_bit;
  logic [WORD_W-1:0] acc;
  logic [WORD_W-1:0] acc_next;
  logic              tick;
  logic              trip;
  logic              word_done;
  logic              push_q;
  logic [WORD_W-1:0] push_word;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;

  for (genvar i = 0; i < NUM_RINGS; i++) begin : g_sync
    logic [1:0] ff;
    always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) ff <= '0;
      else          ff <= {ff[0], ring_clk_i[i]};
    end
    assign sync_q[i] = ff[1];
  end

  assign sample_bit = ^(sync_q & ring_mask_i);
  // >= keeps the prescaler from running away if sample_div_i shrinks mid-count.
  assign tick       = (state == RS_RUN) && (presc >= sample_div_i);
  // rep_cnt == 0 marks the first tick since entering RUN.
  assign rep_next   = ((rep_cnt == '0) || (sample_bit != prev_bit)) ? RW'(1)
                                                                    : rep_cnt + RW'(1);
  assign trip       = tick && (rep_next >= RW'(REP_LIMIT));
  assign word_done  = tick && (bit_cnt == BW'(WORD_W - 1));

  always_comb begin
    acc_next          = acc;
    acc_next[bit_cnt] = sample_bit;
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state         <= RS_IDLE;
      start_o       <= 1'b0;
      busy_o        <= 1'b0;
      warm_cnt      <= '0;
      presc         <= '0;
      bit_cnt       <= '0;
      rep_cnt       <= '0;
      prev_bit      <= 1'b0;
      acc           <= '0;
      health_fail_o <= 1'b0;
      push_q        <= 1'b0;
      push_word     <= '0;
    end else begin
      push_q <= 1'b0;
      if (clear_i) health_fail_o <= 1'b0;
      case (state)
        RS_IDLE: begin
          if (enable_i) begin
            state    <= RS_WARMUP;
            start_o  <= 1'b1;
            busy_o   <= 1'b1;
            warm_cnt <= '0;
          end
        end
        RS_WARMUP: begin
          if (!enable_i) begin
            state    <= RS_IDLE;
            start_o  <= 1'b0;
            busy_o   <= 1'b0;
            warm_cnt <= '0;
          end else if (warm_cnt == WW'(WARMUP_CYCLES - 1)) begin
            state    <= RS_RUN;
            warm_cnt <= '0;
            presc    <= '0;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
            acc      <= '0;
          end else begin
            warm_cnt <= warm_cnt + WW'(1);
          end
        end
        RS_RUN: begin
          // A trip outranks a simultaneous disable so the failure is never lost.
          if (trip || !enable_i) begin
            state    <= trip ? RS_FAULT : RS_IDLE;
            start_o  <= 1'b0;
            busy_o   <= 1'b0;
            presc    <= '0;
            bit_cnt  <= '0;
            rep_cnt  <= '0;
            acc      <= '0;
            if (trip) health_fail_o <= 1'b1;
          end else if (tick) begin
            presc    <= '0;
            prev_bit <= sample_bit;
            rep_cnt  <= rep_next;
            if (word_done) begin
              push_q    <= 1'b1;
              push_word <= acc_next;
              acc       <= '0;
              bit_cnt   <= '0;
            end else begin
              acc     <= acc_next;
              bit_cnt <= bit_cnt + BW'(1);
            end
          end else begin
            presc <= presc + 16'd1;
          end
        end
        RS_FAULT: begin
          if (clear_i) state <= RS_IDLE;
        end
      endcase
    end
  end

  assign pop        = rd_valid_o && rd_ready_i;
  assign rd_valid_o = !fifo_empty;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)                          overflow_o <= 1'b0;
    else if (push_q && fifo_full && !pop)  overflow_o <= 1'b1;
    else if (clear_i)                      overflow_o <= 1'b0;
  end

  ring_sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .rst     (wb_rst_i),
    .wr_en   (push_q),
    .wr_data (push_word),
    .rd_en   (pop),
    .rd_data (rd_data_o),
    .count   (fifo_count_o),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule
